// File: rtl/alu_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// alu_rr_arbiter_if : request/response and ALU-side signal bundle for
//                     alu_rr_arbiter (slave = arbiter, master = requesters/ALU)
// Revision 1.0
// ============================================================================
interface alu_rr_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int OPW   = 3
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [OPW-1:0]   req0_op;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_x;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OPW-1:0]   req1_op;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_x;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_x;

  logic             busy;
  logic [7:0]       grant_cnt0;
  logic [7:0]       grant_cnt1;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
    input  req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
    input  alu_x,
    output req0_ready, rsp0_valid, rsp0_x,
    output req1_ready, rsp1_valid, rsp1_x,
    output alu_a, alu_b, alu_op,
    output busy, grant_cnt0, grant_cnt1
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
    output req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
    output alu_x,
    input  req0_ready, rsp0_valid, rsp0_x,
    input  req1_ready, rsp1_valid, rsp1_x,
    input  alu_a, alu_b, alu_op,
    input  busy, grant_cnt0, grant_cnt1
  );
endinterface
`default_nettype wire

// File: rtl/alu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// alu_rr_arbiter : round-robin sharing of one combinational ALU between two
//                  requesters; optional grant counters under ALU_ARB_STATS_EN
// Revision 1.0
// ============================================================================
module alu_rr_arbiter #(
  parameter int WIDTH = 4,
  parameter int OPW   = 3
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  alu_rr_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             last_grant_q;
  logic             owner_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] res0_q, res1_q;

  logic             sel;
  logic             accept;
  logic             rsp_done;

  // Contested cycles go to whoever did not win last time.
  always_comb begin
    sel = ~last_grant_q;
    if (bus.req0_valid && !bus.req1_valid) begin
      sel = 1'b0;
    end else if (bus.req1_valid && !bus.req0_valid) begin
      sel = 1'b1;
    end
  end

  assign accept   = (state_q == S_IDLE) && (bus.req0_valid || bus.req1_valid);
  assign rsp_done = (state_q == S_RESP) && (owner_q ? bus.rsp1_ready : bus.rsp0_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)   state_d = S_EXEC;
      S_EXEC:                state_d = S_RESP;
      S_RESP:  if (rsp_done) state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    bus.busy       = (state_q != S_IDLE);
    if (state_q == S_IDLE) begin
      bus.req0_ready = bus.req0_valid && !sel;
      bus.req1_ready = bus.req1_valid &&  sel;
    end
    if (state_q == S_RESP) begin
      bus.rsp0_valid = !owner_q;
      bus.rsp1_valid =  owner_q;
    end
  end

  // Per-requester result registers keep each side's last answer visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      res0_q       <= '0;
      res1_q       <= '0;
    end else begin
      if (accept) begin
        owner_q      <= sel;
        last_grant_q <= sel;
        a_q          <= sel ? bus.req1_a  : bus.req0_a;
        b_q          <= sel ? bus.req1_b  : bus.req0_b;
        op_q         <= sel ? bus.req1_op : bus.req0_op;
      end
      if (state_q == S_EXEC) begin
        if (owner_q) begin
          res1_q <= bus.alu_x;
        end else begin
          res0_q <= bus.alu_x;
        end
      end
    end
  end

  assign bus.alu_a  = a_q;
  assign bus.alu_b  = b_q;
  assign bus.alu_op = op_q;
  assign bus.rsp0_x = res0_q;
  assign bus.rsp1_x = res1_q;

`ifdef ALU_ARB_STATS_EN
  logic [7:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= 8'h00;
      cnt1_q <= 8'h00;
    end else if (accept) begin
      if (!sel && (cnt0_q != 8'hFF)) cnt0_q <= cnt0_q + 8'h01;
      if ( sel && (cnt1_q != 8'hFF)) cnt1_q <= cnt1_q + 8'h01;
    end
  end

  assign bus.grant_cnt0 = cnt0_q;
  assign bus.grant_cnt1 = cnt1_q;
`else
  assign bus.grant_cnt0 = 8'h00;
  assign bus.grant_cnt1 = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_alu_rr_arbiter : directed scoreboard bench for alu_rr_arbiter
// Revision 1.0
// ============================================================================
module tb_alu_rr_arbiter;
  localparam int WIDTH = 4;
  localparam int OPW   = 3;
`ifdef ALU_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic       owner;
    logic [3:0] x;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  exp_t mon_e;

  alu_rr_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

  alu_rr_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op);
    case (op)
      3'd0:    return a ^ b;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return a + b;
      3'd4:    return a - b;
      3'd5:    return ~a;
      3'd6:    return {a[2:0], 1'b0};
      default: return b;
    endcase
  endfunction

  always_comb bus.alu_x = alu_model(bus.alu_a, bus.alu_b, bus.alu_op);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic owner, input logic [3:0] x);
    exp_t e;
    e.owner = owner;
    e.x     = x;
    sb.push_back(e);
  endtask

  // Response monitor: pops the scoreboard on every completed response transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.req0_ready || bus.req1_ready)
        check("one_ready", {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
      if (bus.rsp0_valid || bus.rsp1_valid)
        check("one_rsp", {31'd0, bus.rsp0_valid & bus.rsp1_valid}, 32'd0);
      if ((bus.rsp0_valid && bus.rsp0_ready) || (bus.rsp1_valid && bus.rsp1_ready)) begin
        check("rsp_expected", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("rsp_owner", {31'd0, bus.rsp1_valid}, {31'd0, mon_e.owner});
          check("rsp_x", {28'd0, bus.rsp1_valid ? bus.rsp1_x : bus.rsp0_x}, {28'd0, mon_e.x});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    sb.delete();
    @(negedge clk);
    check("rst_busy",   {31'd0, bus.busy}, 32'd0);
    check("rst_ready",  {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
    check("rst_rspv",   {30'd0, bus.rsp0_valid, bus.rsp1_valid}, 32'd0);
    check("rst_alu",    {21'd0, bus.alu_a, bus.alu_b, bus.alu_op}, 32'd0);
    check("rst_rspx",   {24'd0, bus.rsp0_x, bus.rsp1_x}, 32'd0);
    check("rst_cnt",    {16'd0, bus.grant_cnt0, bus.grant_cnt1}, 32'd0);
    tick();
    rst_n = 1'b1;
  endtask

  // Ends at the negedge where the requester's ready is seen; the next tick() accepts.
  task automatic wait_grant(input int who, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = (who == 1) ? bus.req1_ready : bus.req0_ready;
      if (!got) tick();
    end
    check(tag, {31'd0, got}, 32'd1);
  endtask

  task automatic wait_any(output int who);
    who = -1;
    for (int i = 0; i < 30 && who < 0; i++) begin
      @(negedge clk);
      if (bus.req0_ready)      who = 0;
      else if (bus.req1_ready) who = 1;
      else                     tick();
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    check(tag, sb.size(), 32'd0);
  endtask

  initial begin
    int who;
    clear_inputs();
    tick();

    // Single operation: XOR stub, two-cycle busy window.
    do_reset();
    bus.rsp0_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 4'b1100; bus.req0_b = 4'b0111; bus.req0_op = 3'd0;
    push(1'b0, 4'b1011);
    @(negedge clk);
    check("single_ready0", {31'd0, bus.req0_ready}, 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    @(negedge clk);
    check("single_exec_busy", {31'd0, bus.busy}, 32'd1);
    check("single_exec_alu", {21'd0, bus.alu_a, bus.alu_b, bus.alu_op}, {21'd0, 4'b1100, 4'b0111, 3'd0});
    check("single_exec_rspv", {31'd0, bus.rsp0_valid}, 32'd0);
    tick();
    @(negedge clk);
    check("single_rspv", {31'd0, bus.rsp0_valid}, 32'd1);
    check("single_rspx", {28'd0, bus.rsp0_x}, {28'd0, 4'b1011});
    check("single_resp_busy", {31'd0, bus.busy}, 32'd1);
    tick();
    @(negedge clk);
    check("single_idle_busy", {31'd0, bus.busy}, 32'd0);
    check("single_hold_x", {28'd0, bus.rsp0_x}, {28'd0, 4'b1011});
    tick();

    // Contention from reset: strict alternation starting with requester 0.
    do_reset();
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 4'b0001; bus.req0_b = 4'b0100; bus.req0_op = 3'd0;
    bus.req1_valid = 1'b1; bus.req1_a = 4'b0011; bus.req1_b = 4'b0101; bus.req1_op = 3'd0;
    push(1'b0, 4'b0101); push(1'b1, 4'b0110); push(1'b0, 4'b0101); push(1'b1, 4'b0110);
    for (int i = 0; i < 4; i++) begin
      wait_any(who);
      check("rr_order", who, i % 2);
      tick();
      if (i == 2) bus.req0_valid = 1'b0;
      if (i == 3) bus.req1_valid = 1'b0;
    end
    wait_drain("rr_drain");

    // Response backpressure on requester 1 while requester 0 waits.
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 4'h9; bus.req1_b = 4'h3; bus.req1_op = 3'd1;
    push(1'b1, 4'h1);
    wait_grant(1, "bp_grant1");
    tick();
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 4'h2; bus.req0_b = 4'h2; bus.req0_op = 3'd3;
    push(1'b0, 4'h4);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp1v", {31'd0, bus.rsp1_valid}, 32'd1);
      check("bp_rsp1x", {28'd0, bus.rsp1_x}, 32'h1);
      check("bp_ready0", {31'd0, bus.req0_ready}, 32'd0);
      check("bp_busy", {31'd0, bus.busy}, 32'd1);
      tick();
    end
    bus.rsp1_ready = 1'b1;
    tick();
    @(negedge clk);
    check("bp_next_ready0", {31'd0, bus.req0_ready}, 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    wait_drain("bp_drain");

    // Opcode sweep on requester 0.
    for (int op = 0; op < 8; op++) begin
      bus.req0_valid = 1'b1; bus.req0_a = 4'hA; bus.req0_b = 4'h6; bus.req0_op = 3'(op);
      push(1'b0, alu_model(4'hA, 4'h6, 3'(op)));
      wait_grant(0, "sweep_grant");
      tick();
      bus.req0_valid = 1'b0;
      @(negedge clk);
      check("sweep_alu_op", {29'd0, bus.alu_op}, op);
      tick();
    end
    wait_drain("sweep_drain");

    // Asynchronous reset during EXEC drops the operation.
    bus.req0_valid = 1'b1; bus.req0_a = 4'hF; bus.req0_b = 4'h1; bus.req0_op = 3'd3;
    wait_grant(0, "arst_grant");
    tick();
    bus.req0_valid = 1'b0;
    #2;
    check("arst_pre_busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_rspv", {30'd0, bus.rsp0_valid, bus.rsp1_valid}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    bus.req1_valid = 1'b1; bus.req1_a = 4'h5; bus.req1_b = 4'h3; bus.req1_op = 3'd0;
    push(1'b1, 4'h6);
    wait_grant(1, "arst_fresh_grant1");
    tick();
    bus.req1_valid = 1'b0;
    wait_drain("arst_drain");
    check("arst_cnt0", {24'd0, bus.grant_cnt0}, 32'd0);
    check("arst_cnt1", {24'd0, bus.grant_cnt1}, STATS ? 32'd1 : 32'd0);

    // 300 grants to requester 0: counter saturation (or tied-off zero).
    do_reset();
    bus.rsp0_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [7:0] v;
      v = 8'(i);
      bus.req0_valid = 1'b1; bus.req0_a = v[3:0]; bus.req0_b = v[7:4]; bus.req0_op = 3'd3;
      push(1'b0, alu_model(v[3:0], v[7:4], 3'd3));
      wait_grant(0, "sat_grant");
      tick();
      bus.req0_valid = 1'b0;
    end
    wait_drain("sat_drain");
    @(negedge clk);
    check("sat_cnt0", {24'd0, bus.grant_cnt0}, STATS ? 32'hFF : 32'd0);
    check("sat_cnt1", {24'd0, bus.grant_cnt1}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
